// File: rtl/mcd_arb_pkg.sv
// Shared types and helpers for the memcached DRAM read arbiter:
// master indices, arbiter FSM states and the round-robin priority encoder.
package mcd_arb_pkg;

  localparam int MST_HT    = 0;
  localparam int MST_VS    = 1;
  localparam int MST_BUDDY = 2;
  localparam int MAX_MST   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // Returns {found, index}: the first set request at or after ptr, wrapping modulo n.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr,
                                         input logic [2:0] n);
    logic [2:0] res;
    logic [2:0] idx;
    res = '0;
    // Scan from the farthest slot back to ptr so the nearest eligible one wins.
    for (int k = 3; k >= 0; k--) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= n) idx = idx - n;
      if ((3'(k) < n) && req[idx[1:0]]) res = {1'b1, idx[1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/mcd_outst_ctr.sv
// Per-master count of in-flight read bursts; full stops further grants.
module mcd_outst_ctr #(
  parameter int MAX_OUTST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [CW-1:0] cnt;

  // inc is only raised while not full, and dec below zero is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign full = (cnt == CW'(MAX_OUTST));

endmodule

// File: rtl/mcd_dram_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_MST memcached masters.
// Optional per-master grant/beat statistics are built when MCD_RD_ARB_STATS_EN is defined.
module mcd_dram_rd_arbiter
  import mcd_arb_pkg::*;
#(
  parameter int NUM_MST   = 3,
  parameter int ADDR_WID  = 32,
  parameter int DATA_WID  = 512,
  parameter int ID_WID    = 5,
  parameter int MAX_OUTST = 8
) (
  input  logic                     mem_clk,
  input  logic                     mem_rst,
  input  logic [NUM_MST-1:0]       s_arvalid,
  output logic [NUM_MST-1:0]       s_arready,
  input  logic [NUM_MST*ADDR_WID-1:0] s_araddr,
  input  logic [NUM_MST*8-1:0]     s_arlen,
  output logic [NUM_MST-1:0]       s_rvalid,
  input  logic [NUM_MST-1:0]       s_rready,
  output logic [DATA_WID-1:0]      s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_WID-1:0]      m_araddr,
  output logic [7:0]               m_arlen,
  output logic [ID_WID-1:0]        m_arid,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [DATA_WID-1:0]      m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic [ID_WID-1:0]        m_rid,
`ifdef MCD_RD_ARB_STATS_EN
  output logic [NUM_MST*32-1:0]    grant_cnt,
  output logic [NUM_MST*32-1:0]    beat_cnt,
`endif
  output logic                     rid_err,
  output logic                     dbg_state
);

  localparam int IDX_W = 2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid source keeps its payload stable until then, and ready may depend on valid.

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, gnt_idx;
  logic [NUM_MST-1:0]   full, elig, inc, dec;
  logic [MAX_MST-1:0]   req4;
  logic [2:0]           pick;
  logic                 ar_load, ar_done;
  logic [ADDR_WID-1:0]  sel_addr, araddr_q;
  logic [7:0]           sel_len, arlen_q;
  logic                 rid_ok;
  logic [IDX_W-1:0]     rid_idx;

  assign elig = s_arvalid & ~full;

  always_comb begin
    req4 = '0;
    req4[NUM_MST-1:0] = elig;
  end

  assign pick = rr_pick(req4, rr_ptr, 3'(NUM_MST));

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (pick[1:0] == IDX_W'(i)) begin
        sel_addr = s_araddr[i*ADDR_WID +: ADDR_WID];
        sel_len  = s_arlen[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    ar_load   = 1'b0;
    ar_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_rst && pick[2]) begin
          ar_load   = 1'b1;
          state_nxt = ISSUE;
          for (int i = 0; i < NUM_MST; i++) s_arready[i] = (pick[1:0] == IDX_W'(i));
        end
      end
      ISSUE: begin
        if (m_arready) begin
          ar_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      rid_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_load) begin
        gnt_idx  <= pick[1:0];
        araddr_q <= sel_addr;
        arlen_q  <= sel_len;
      end
      if (ar_done) rr_ptr <= (gnt_idx == IDX_W'(NUM_MST - 1)) ? '0 : gnt_idx + IDX_W'(1);
      if (m_rvalid && !rid_ok) rid_err <= 1'b1;
    end
  end

  assign m_arvalid = (state == ISSUE);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arid    = ID_WID'(gnt_idx);
  assign dbg_state = state;

  // Any id outside the master range (including nonzero upper bits) is drained and dropped.
  assign rid_ok  = (m_rid < ID_WID'(NUM_MST));
  assign rid_idx = m_rid[IDX_W-1:0];

  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    for (int i = 0; i < NUM_MST; i++) begin
      s_rvalid[i] = m_rvalid && rid_ok && (rid_idx == IDX_W'(i));
      if (rid_ok && (rid_idx == IDX_W'(i))) m_rready = s_rready[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      inc[i] = ar_done && (gnt_idx == IDX_W'(i));
      dec[i] = s_rvalid[i] && m_rready && m_rlast;
    end
  end

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  for (genvar i = 0; i < NUM_MST; i++) begin : g_ctr
    mcd_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_ctr (
      .clk  (mem_clk),
      .rst  (mem_rst),
      .inc  (inc[i]),
      .dec  (dec[i]),
      .full (full[i])
    );
  end

`ifdef MCD_RD_ARB_STATS_EN
  logic [31:0] gcnt [NUM_MST];
  logic [31:0] bcnt [NUM_MST];

  always_ff @(posedge mem_clk) begin
    for (int i = 0; i < NUM_MST; i++) begin
      if (mem_rst) begin
        gcnt[i] <= '0;
        bcnt[i] <= '0;
      end else begin
        if (inc[i]) gcnt[i] <= gcnt[i] + 32'd1;
        if (s_rvalid[i] && m_rready) bcnt[i] <= bcnt[i] + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_MST; i++) begin : g_stats
    assign grant_cnt[i*32 +: 32] = gcnt[i];
    assign beat_cnt[i*32 +: 32]  = bcnt[i];
  end
`endif

endmodule

// File: tb/tb_mcd_dram_rd_arbiter.sv
// Self-checking bench for mcd_dram_rd_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mcd_dram_rd_arbiter;

  localparam int NM        = 3;
  localparam int MAX_OUTST = 8;

  logic            mem_clk = 1'b0;
  logic            mem_rst;
  logic [NM-1:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NM*32-1:0] s_araddr;
  logic [NM*8-1:0] s_arlen;
  logic [511:0]    s_rdata, m_rdata;
  logic [1:0]      s_rresp, m_rresp;
  logic            s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [4:0]      m_arid, m_rid;
  logic            rid_err, dbg_state;

  mcd_dram_rd_arbiter #(.NUM_MST(NM), .ADDR_WID(32), .DATA_WID(512), .ID_WID(5),
                        .MAX_OUTST(MAX_OUTST)) dut (
    .mem_clk(mem_clk), .mem_rst(mem_rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .rid_err(rid_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 mem_clk = ~mem_clk;

  // scoreboard and reference model state
  int          total = 0;
  int          bad   = 0;
  int          outst [NM];
  int          rr;
  bit          busy;
  int          g;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  bit          err;
  bit          last_beat;
  bit          track_ids;
  int          obs_gnt [NM];
  logic [4:0]  exp_q [$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NM; i++) outst[i] = 0;
    rr = 0; busy = 0; g = 0; err = 0; ar_addr = '0; ar_len = '0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int gm, rid, m;
    logic [NM-1:0] exp_ardy, exp_srv;
    logic exp_rr;
    bit good;
    @(negedge mem_clk);
    gm = -1;
    if (!mem_rst && !busy)
      for (int k = 0; k < NM; k++) begin
        m = (rr + k) % NM;
        if (gm < 0 && s_arvalid[m] && outst[m] < MAX_OUTST) gm = m;
      end
    exp_ardy = (gm >= 0) ? NM'(1 << gm) : '0;
    rid  = int'(m_rid);
    good = (rid < NM);
    exp_srv = (m_rvalid && good) ? NM'(1 << rid) : '0;
    exp_rr  = good ? s_rready[rid] : 1'b1;
    check("s_arready", 512'(s_arready), 512'(exp_ardy));
    check("m_arvalid", 512'(m_arvalid), 512'(busy));
    check("dbg_state", 512'(dbg_state), 512'(busy));
    if (busy) begin
      check("m_araddr", 512'(m_araddr), 512'(ar_addr));
      check("m_arlen", 512'(m_arlen), 512'(ar_len));
      check("m_arid", 512'(m_arid), 512'(5'(g)));
    end
    check("s_rvalid", 512'(s_rvalid), 512'(exp_srv));
    check("m_rready", 512'(m_rready), 512'(exp_rr));
    check("s_rdata", s_rdata, m_rdata);
    check("s_rresp_last", 512'({s_rresp, s_rlast}), 512'({m_rresp, m_rlast}));
    check("rid_err", 512'(rid_err), 512'(err));
    if (track_ids && m_arvalid && m_arready && exp_q.size() > 0)
      check("rr_seq", 512'(m_arid), 512'(exp_q.pop_front()));
    if (m_arvalid && m_arready && m_arid < NM) obs_gnt[int'(m_arid)]++;
    last_beat = m_rvalid && exp_rr && good;
    if (mem_rst) begin
      model_reset();
    end else begin
      if (busy && m_arready) begin
        outst[g]++;
        rr = (g + 1) % NM;
        busy = 0;
      end else if (!busy && gm >= 0) begin
        busy = 1; g = gm;
        ar_addr = s_araddr[gm*32 +: 32];
        ar_len  = s_arlen[gm*8 +: 8];
      end
      if (m_rvalid && good && exp_rr && m_rlast) outst[rid]--;
      if (m_rvalid && !good) err = 1;
    end
    @(posedge mem_clk); #1;
  endtask

  // driver tasks
  task automatic rand_addrs();
    s_araddr = {$urandom, $urandom, $urandom};
    s_arlen  = 24'($urandom);
  endtask

  task automatic rand_rdata();
    for (int k = 0; k < 16; k++) m_rdata[k*32 +: 32] = $urandom;
    m_rresp = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    s_arvalid = '0; m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0;
    step(); step();
    for (int i = 0; i < NM; i++)
      for (int n = 0; n < 40 && outst[i] > 0; n++) begin
        m_rvalid = 1'b1; m_rid = 5'(i); m_rlast = 1'b1; s_rready = '1;
        rand_rdata();
        step();
      end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    for (int i = 0; i < NM; i++) check("drain_done", 512'(outst[i] == 0), 512'(1));
  endtask

  initial begin
    int beats, r;
    logic tog;
    model_reset();
    track_ids = 0;
    for (int i = 0; i < NM; i++) obs_gnt[i] = 0;
    mem_rst = 1'b1; s_arvalid = '1; s_rready = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
    rand_addrs();
    @(posedge mem_clk); #1;

    // reset held with every master requesting
    repeat (3) step();
    mem_rst = 1'b0; s_arvalid = '0;
    step();

    // round-robin order
    m_arready = 1'b1; s_arvalid = '1; track_ids = 1;
    exp_q = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2};
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      rand_addrs();
      step();
    end
    track_ids = 0;
    check("rr_seq_done", 512'(exp_q.size()), 512'(0));
    drain();

    // outstanding cap on master 1
    for (int i = 0; i < NM; i++) obs_gnt[i] = 0;
    s_arvalid = 3'b010; m_arready = 1'b1;
    repeat (24) begin rand_addrs(); step(); end
    check("cap_grants", 512'(obs_gnt[1]), 512'(8));
    check("cap_stall", 512'(s_arready[1]), 512'(0));
    m_rvalid = 1'b1; m_rid = 5'd1; m_rlast = 1'b1; s_rready = 3'b010;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (4) step();
    check("cap_regrant", 512'(obs_gnt[1]), 512'(9));
    drain();

    // AR backpressure
    s_arvalid = 3'b001; m_arready = 1'b0;
    step();
    s_arvalid = '1;
    repeat (5) begin rand_addrs(); step(); end
    check("bp_hold", 512'(m_arvalid), 512'(1));
    m_arready = 1'b1;
    step();
    drain();

    // R routing: 4-beat burst on id 2 with toggling ready
    s_arvalid = 3'b100; m_arready = 1'b1;
    step(); step();
    s_arvalid = '0;
    step();
    beats = 0; tog = 1'b0;
    for (int n = 0; n < 40 && beats < 4; n++) begin
      m_rvalid = 1'b1; m_rid = 5'd2; m_rlast = (beats == 3);
      s_rready = {tog, 2'($urandom_range(0, 3))};
      tog = ~tog;
      rand_rdata();
      step();
      if (last_beat) beats++;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("burst_beats", 512'(beats), 512'(4));

    // unknown RIDs
    m_rvalid = 1'b1; m_rid = 5'd3; m_rlast = 1'b1; s_rready = '0;
    step();
    m_rid = 5'd5;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (3) step();
    check("rid_err_sticky", 512'(rid_err), 512'(1));

    // reset while an AR is pending
    s_arvalid = 3'b011; m_arready = 1'b0;
    step(); step();
    mem_rst = 1'b1;
    step();
    mem_rst = 1'b0; s_arvalid = '0; m_arready = 1'b1;
    step();
    check("post_rst_rid_err", 512'(rid_err), 512'(0));
    check("post_rst_idle", 512'(m_arvalid), 512'(0));

    // random traffic
    repeat (1500) begin
      s_arvalid = NM'($urandom_range(0, 7));
      m_arready = ($urandom_range(0, 3) != 0);
      rand_addrs();
      rand_rdata();
      m_rvalid = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      m_rid = (r < 14) ? 5'(r % NM) : ((r == 14) ? 5'd3 : 5'd9);
      m_rlast = (m_rid < NM) && (outst[int'(m_rid)] > 0) && ($urandom_range(0, 1) == 1);
      s_rready = NM'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
